// File: rtl/triangle_wave_monitor.sv
// Triangle wave monitor: tracks slope direction of a sampled wave and
// recovers peak, trough and trough-to-trough period in accepted samples.
module triangle_wave_monitor #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        wave_in,
  output logic [WIDTH-1:0]        high_out,
  output logic [WIDTH-1:0]        low_out,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output logic                    dir_out,
  output logic                    valid_out,
  output logic                    locked_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIMED  = 2'd1,
    RISING  = 2'd2,
    FALLING = 2'd3
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]        high_q, high_d;
  logic [WIDTH-1:0]        low_q, low_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    dir_q, dir_d;
  logic                    valid_q, valid_d;
  logic                    locked_q, locked_d;
  logic                    seen_q, seen_d;   // a trough has been detected since reset

  // Next-state: slope tracking, extreme capture and period counting on accepted samples.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    locked_d = locked_q;
    seen_d   = seen_q;
    valid_d  = 1'b0;
    if (enable) begin
      prev_d = wave_in;
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_WIDTH'(1);
      unique case (state_q)
        IDLE: state_d = PRIMED;
        PRIMED: begin
          if (wave_in > prev_q)      state_d = RISING;
          else if (wave_in < prev_q) state_d = FALLING;
        end
        RISING: begin
          if (wave_in < prev_q) begin
            high_d  = prev_q;
            state_d = FALLING;
          end
        end
        FALLING: begin
          if (wave_in > prev_q) begin
            low_d   = prev_q;
            state_d = RISING;
            // Detecting sample opens the new period.
            cnt_d   = PERIOD_WIDTH'(1);
            seen_d  = 1'b1;
            if (seen_q) begin
              period_d = cnt_q;
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    dir_d = (state_d == RISING);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      cnt_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      seen_q   <= seen_d;
    end
  end

  assign high_out   = high_q;
  assign low_out    = low_q;
  assign period_out = period_q;
  assign dir_out    = dir_q;
  assign valid_out  = valid_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_triangle_wave_monitor.sv
// Randomized bench for triangle_wave_monitor against a sample-history reference model.
module tb_triangle_wave_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  wave_in;
  logic [3:0]  high_out, low_out, high_s, low_s;
  logic [15:0] period_out;
  logic [3:0]  period_s;
  logic        dir_out, valid_out, locked_out;
  logic        dir_s, valid_s, locked_s;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_prev, m_trend, m_cnt, m_troughs;
  int  m_high, m_low, m_per, m_valid, m_locked;
  bit  m_have;

  always #5 clk = ~clk;

  triangle_wave_monitor #(.WIDTH(4), .PERIOD_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wave_in(wave_in),
    .high_out(high_out), .low_out(low_out), .period_out(period_out),
    .dir_out(dir_out), .valid_out(valid_out), .locked_out(locked_out)
  );

  triangle_wave_monitor #(.WIDTH(4), .PERIOD_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .wave_in(wave_in),
    .high_out(high_s), .low_out(low_s), .period_out(period_s),
    .dir_out(dir_s), .valid_out(valid_s), .locked_out(locked_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_trend = 0; m_cnt = 0; m_troughs = 0; m_have = 0;
    m_high = 0; m_low = 0; m_per = 0; m_valid = 0; m_locked = 0;
  endtask

  // Peak/trough found by comparing each sample with the previous one and the last non-flat trend.
  task automatic model_accept(input int s);
    m_valid = 0;
    if (m_have) begin
      if (s > m_prev) begin
        if (m_trend == -1) begin
          m_low = m_prev;
          if (m_troughs > 0) begin
            m_per = m_cnt; m_valid = 1; m_locked = 1;
          end
          m_troughs++;
          m_cnt = 0;
        end
        m_trend = 1;
      end else if (s < m_prev) begin
        if (m_trend == 1) m_high = m_prev;
        m_trend = -1;
      end
    end
    m_have = 1;
    m_prev = s;
    m_cnt++;
  endtask

  task automatic compare_all();
    check("high",   int'(high_out),   m_high);
    check("low",    int'(low_out),    m_low);
    check("period", int'(period_out), sat(m_per, 65535));
    check("dir",    int'(dir_out),    (m_trend == 1) ? 1 : 0);
    check("valid",  int'(valid_out),  m_valid);
    check("locked", int'(locked_out), m_locked);
    check("s_period", int'(period_s), sat(m_per, 15));
    check("s_valid",  int'(valid_s),  m_valid);
    check("s_locked", int'(locked_s), m_locked);
  endtask

  task automatic step(input bit en, input int w);
    @(negedge clk);
    enable  = en;
    wave_in = 4'(w);
    @(posedge clk);
    if (en) model_accept(w);
    else    m_valid = 0;
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 1-step triangle between lo and hi; with gaps, enable drops at random and wave_in carries junk.
  task automatic tri_wave(input int lo, input int hi, input int start, input int dir,
                          input int nsamp, input bit gaps);
    int v, d;
    v = start; d = dir;
    for (int i = 0; i < nsamp; i++) begin
      if (gaps && ($urandom_range(0, 6) < 3)) begin
        step(1'b0, int'($urandom_range(0, 15)));
      end else begin
        step(1'b1, v);
        if (d == 1) begin
          if (v >= hi) begin d = -1; v--; end else v++;
        end else begin
          if (v <= lo) begin d = 1; v++; end else v--;
        end
      end
    end
  endtask

  initial begin
    int plat [9] = '{0, 1, 2, 2, 2, 1, 0, 0, 1};
    rst = 1'b1; enable = 1'b0; wave_in = '0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk); rst = 1'b0;

    // Nominal 0..13 triangle
    tri_wave(0, 13, 0, 1, 26 * 4, 1'b0);
    check("nom_high", int'(high_out), 13);
    check("nom_low", int'(low_out), 0);
    check("nom_period", int'(period_out), 26);
    check("nom_locked", int'(locked_out), 1);
    check("nom_sat_period", int'(period_s), 15);

    // Reset in the middle of a rising slope, then restart
    tri_wave(0, 13, 0, 1, 6, 1'b0);
    async_reset();
    tri_wave(0, 13, 0, 1, 26 * 3, 1'b0);

    // Enable gaps with junk on wave_in
    tri_wave(0, 13, 0, 1, 26 * 8, 1'b1);
    check("gap_period", int'(period_out), 26);

    // Amplitude change: low 0 -> 5, then high 13 -> 10
    tri_wave(5, 13, 5, 1, 16 * 5, 1'b0);
    check("amp_low", int'(low_out), 5);
    check("amp_high", int'(high_out), 13);
    check("amp_period", int'(period_out), 16);
    tri_wave(5, 10, 6, 1, 10 * 6, 1'b0);
    check("amp2_high", int'(high_out), 10);
    check("amp2_low", int'(low_out), 5);
    check("amp2_period", int'(period_out), 10);

    // Plateaus
    async_reset();
    for (int i = 0; i < 9; i++) step(1'b1, plat[i]);
    check("plat_high", int'(high_out), 2);
    check("plat_low", int'(low_out), 0);
    check("plat_valid", int'(valid_out), 0);

    // Constant input: no pulses
    for (int i = 0; i < 20; i++) step(1'b1, 7);

    // Random samples including wrap-style drops
    for (int i = 0; i < 400; i++) step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
